// File: rtl/noc_local_ni.sv
// Multi-channel Phoenix local network interface: buffered, credit-correct injection/ejection with packet parsing.
// Define NOC_NI_STATS_EN to add saturating per-channel sent/received packet counters.

module noc_ni_fifo #(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, empty_q;
   logic          push, pop;

   // Requests are qualified by the registered flags only.
   assign push    = push_i & ~full_q;
   assign pop     = pop_i & ~empty_q;
   assign count_d = count_q + CW'(push) - CW'(pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
endmodule

module noc_ni_parser #(
   parameter int unsigned W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         adv_i,
   input  logic [W-1:0] flit_i,
   output logic         last_c_o
);
   typedef enum logic [1:0] {HDR, SIZE, PAY} state_e;

   state_e       state_q;
   logic [W-1:0] cnt_q;

   // Current flit closes the packet: zero-size flit, or final payload flit.
   assign last_c_o = ((state_q == SIZE) && (flit_i == '0)) ||
                     ((state_q == PAY) && (cnt_q == W'(1)));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= HDR;
         cnt_q   <= '0;
      end else if (adv_i) begin
         case (state_q)
            HDR:  state_q <= SIZE;
            SIZE: begin
               if (flit_i == '0) begin
                  state_q <= HDR;
               end else begin
                  cnt_q   <= flit_i;
                  state_q <= PAY;
               end
            end
            PAY: begin
               cnt_q <= cnt_q - W'(1);
               if (cnt_q == W'(1)) state_q <= HDR;
            end
            default: state_q <= HDR;
         endcase
      end
   end
endmodule

module noc_local_ni #(
   parameter int unsigned NCH      = 4,
   parameter int unsigned TAM_FLIT = 16,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NCH-1:0]          usr_wr,
   input  logic [NCH*TAM_FLIT-1:0] usr_wdata,
   output logic [NCH-1:0]          usr_full,
   input  logic [NCH-1:0]          usr_rd,
   output logic [NCH*TAM_FLIT-1:0] usr_rdata,
   output logic [NCH-1:0]          usr_empty,
   output logic [NCH-1:0]          usr_eop,
   output logic [NCH-1:0]          noc_rx,
   output logic [NCH*TAM_FLIT-1:0] noc_data_in,
   input  logic [NCH-1:0]          noc_credit_i,
   input  logic [NCH-1:0]          noc_tx,
   input  logic [NCH*TAM_FLIT-1:0] noc_data_out,
   output logic [NCH-1:0]          noc_credit_o,
   output logic [NCH-1:0]          pkt_sent,
   output logic [NCH-1:0]          pkt_rcvd
`ifdef NOC_NI_STATS_EN
   ,
   output logic [NCH*16-1:0]       tx_pkt_count,
   output logic [NCH*16-1:0]       rx_pkt_count
`endif
);
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [TAM_FLIT-1:0] tx_head, rx_flit;
      logic [TAM_FLIT:0]   rx_head;
      logic                tx_full, tx_empty, tx_xfer, tx_last;
      logic                rx_full, rx_empty, rx_acc, rx_last, rx_credit;
      logic                sent_q, rcvd_q;

      assign tx_xfer   = noc_credit_i[c] & ~tx_empty;
      assign rx_flit   = noc_data_out[c*TAM_FLIT +: TAM_FLIT];
      // Credit comes from the registered full flag, so a pop frees space only next cycle.
      assign rx_credit = ~rx_full & ~reset;
      assign rx_acc    = noc_tx[c] & rx_credit;

      noc_ni_fifo #(.W(TAM_FLIT), .DEPTH(DEPTH)) u_tx_fifo (
         .clock(clock), .reset(reset),
         .push_i(usr_wr[c]), .pop_i(noc_credit_i[c]),
         .wdata_i(usr_wdata[c*TAM_FLIT +: TAM_FLIT]),
         .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
      );

      noc_ni_parser #(.W(TAM_FLIT)) u_tx_parser (
         .clock(clock), .reset(reset),
         .adv_i(tx_xfer), .flit_i(tx_head), .last_c_o(tx_last)
      );

      noc_ni_fifo #(.W(TAM_FLIT + 1), .DEPTH(DEPTH)) u_rx_fifo (
         .clock(clock), .reset(reset),
         .push_i(rx_acc), .pop_i(usr_rd[c]),
         .wdata_i({rx_last, rx_flit}),
         .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
      );

      noc_ni_parser #(.W(TAM_FLIT)) u_rx_parser (
         .clock(clock), .reset(reset),
         .adv_i(rx_acc), .flit_i(rx_flit), .last_c_o(rx_last)
      );

      always_ff @(posedge clock) begin
         if (reset) begin
            sent_q <= 1'b0;
            rcvd_q <= 1'b0;
         end else begin
            sent_q <= tx_xfer & tx_last;
            rcvd_q <= rx_acc & rx_last;
         end
      end

      assign usr_full[c]                          = tx_full;
      assign noc_rx[c]                            = ~tx_empty;
      assign noc_data_in[c*TAM_FLIT +: TAM_FLIT]  = tx_head;
      assign usr_empty[c]                         = rx_empty;
      assign usr_rdata[c*TAM_FLIT +: TAM_FLIT]    = rx_head[TAM_FLIT-1:0];
      assign usr_eop[c]                           = rx_head[TAM_FLIT] & ~rx_empty;
      assign noc_credit_o[c]                      = rx_credit;
      assign pkt_sent[c]                          = sent_q;
      assign pkt_rcvd[c]                          = rcvd_q;

`ifdef NOC_NI_STATS_EN
      logic [15:0] tx_cnt_q, rx_cnt_q;

      // Counters step on the pulse cycle and stick at all-ones.
      always_ff @(posedge clock) begin
         if (reset) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
         end else begin
            if (sent_q && (tx_cnt_q != 16'hFFFF)) tx_cnt_q <= tx_cnt_q + 16'd1;
            if (rcvd_q && (rx_cnt_q != 16'hFFFF)) rx_cnt_q <= rx_cnt_q + 16'd1;
         end
      end

      assign tx_pkt_count[c*16 +: 16] = tx_cnt_q;
      assign rx_pkt_count[c*16 +: 16] = rx_cnt_q;
`else
      // Statistics counters are not built in this configuration.
`endif
   end
endmodule

// File: tb/tb_noc_local_ni.sv
// Directed bench for noc_local_ni: queue-level reference model checked every cycle plus literal spot checks.
// Counter checks are compiled in when NOC_NI_STATS_EN is defined.

module tb_noc_local_ni;
   localparam int NCH   = 4;
   localparam int TF    = 16;
   localparam int DEPTH = 4;

   logic              clock, reset;
   logic [NCH-1:0]    usr_wr, usr_full, usr_rd, usr_empty, usr_eop;
   logic [NCH-1:0]    noc_rx, noc_credit_i, noc_tx, noc_credit_o, pkt_sent, pkt_rcvd;
   logic [NCH*TF-1:0] usr_wdata, usr_rdata, noc_data_in, noc_data_out;
`ifdef NOC_NI_STATS_EN
   logic [NCH*16-1:0] tx_pkt_count, rx_pkt_count;
`endif

   noc_local_ni #(.NCH(NCH), .TAM_FLIT(TF), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .usr_wr(usr_wr), .usr_wdata(usr_wdata), .usr_full(usr_full),
      .usr_rd(usr_rd), .usr_rdata(usr_rdata), .usr_empty(usr_empty), .usr_eop(usr_eop),
      .noc_rx(noc_rx), .noc_data_in(noc_data_in), .noc_credit_i(noc_credit_i),
      .noc_tx(noc_tx), .noc_data_out(noc_data_out), .noc_credit_o(noc_credit_o),
      .pkt_sent(pkt_sent), .pkt_rcvd(pkt_rcvd)
`ifdef NOC_NI_STATS_EN
      , .tx_pkt_count(tx_pkt_count), .rx_pkt_count(rx_pkt_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   task automatic check(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s ch%0d actual=%h required=%h t=%0t", nm, ch, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] lane(input logic [NCH*TF-1:0] v, input int c);
      return v[c*TF +: TF];
   endfunction

   // Reference model: per-channel flit queues and packet position counters.
   logic [15:0]    tx_m [NCH][DEPTH];
   logic [16:0]    rx_m [NCH][DEPTH];
   int             tx_n [NCH], rx_n [NCH];
   int             tx_pos [NCH], tx_size [NCH], rx_pos [NCH], rx_size [NCH];
   int             exp_txc [NCH], exp_rxc [NCH];
   logic [NCH-1:0] exp_sent = '0, exp_rcvd = '0;

   function automatic bit pkt_last(input int pos, input int size, input logic [15:0] f);
      return (pos == 1 && f == 16'h0) || (pos >= 2 && pos == size + 1);
   endfunction

   always @(posedge clock) begin
      bit          xfer, pushok, acc, popok, last;
      logic [15:0] f;
      for (int c = 0; c < NCH; c++) begin
         if (reset) begin
            tx_n[c] = 0; rx_n[c] = 0;
            tx_pos[c] = 0; tx_size[c] = 0; rx_pos[c] = 0; rx_size[c] = 0;
            exp_txc[c] = 0; exp_rxc[c] = 0;
            exp_sent[c] = 1'b0; exp_rcvd[c] = 1'b0;
         end else begin
            if (exp_sent[c] && exp_txc[c] < 65535) exp_txc[c]++;
            if (exp_rcvd[c] && exp_rxc[c] < 65535) exp_rxc[c]++;
            xfer   = (tx_n[c] > 0) && noc_credit_i[c];
            pushok = usr_wr[c] && (tx_n[c] < DEPTH);
            acc    = noc_tx[c] && (rx_n[c] < DEPTH);
            popok  = usr_rd[c] && (rx_n[c] > 0);
            exp_sent[c] = 1'b0;
            exp_rcvd[c] = 1'b0;
            if (xfer) begin
               f = tx_m[c][0];
               last = pkt_last(tx_pos[c], tx_size[c], f);
               if (tx_pos[c] == 1) tx_size[c] = int'(f);
               tx_pos[c] = last ? 0 : tx_pos[c] + 1;
               exp_sent[c] = last;
               for (int i = 0; i < DEPTH - 1; i++) tx_m[c][i] = tx_m[c][i+1];
               tx_n[c]--;
            end
            if (pushok) begin
               tx_m[c][tx_n[c]] = lane(usr_wdata, c);
               tx_n[c]++;
            end
            if (popok) begin
               for (int i = 0; i < DEPTH - 1; i++) rx_m[c][i] = rx_m[c][i+1];
               rx_n[c]--;
            end
            if (acc) begin
               f = lane(noc_data_out, c);
               last = pkt_last(rx_pos[c], rx_size[c], f);
               if (rx_pos[c] == 1) rx_size[c] = int'(f);
               rx_pos[c] = last ? 0 : rx_pos[c] + 1;
               exp_rcvd[c] = last;
               rx_m[c][rx_n[c]] = {last, f};
               rx_n[c]++;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (chk_en) begin
         for (int c = 0; c < NCH; c++) begin
            check("noc_rx", c, 32'(noc_rx[c]), 32'(tx_n[c] != 0));
            if (tx_n[c] != 0) check("noc_data_in", c, 32'(lane(noc_data_in, c)), 32'(tx_m[c][0]));
            check("usr_full", c, 32'(usr_full[c]), 32'(tx_n[c] == DEPTH));
            check("usr_empty", c, 32'(usr_empty[c]), 32'(rx_n[c] == 0));
            if (rx_n[c] != 0) check("usr_rdata", c, 32'(lane(usr_rdata, c)), 32'(rx_m[c][0][15:0]));
            check("usr_eop", c, 32'(usr_eop[c]), 32'((rx_n[c] != 0) && rx_m[c][0][16]));
            check("noc_credit_o", c, 32'(noc_credit_o[c]), 32'(!reset && rx_n[c] < DEPTH));
            check("pkt_sent", c, 32'(pkt_sent[c]), 32'(exp_sent[c]));
            check("pkt_rcvd", c, 32'(pkt_rcvd[c]), 32'(exp_rcvd[c]));
`ifdef NOC_NI_STATS_EN
            check("tx_pkt_count", c, 32'(tx_pkt_count[c*16 +: 16]), 32'(exp_txc[c]));
            check("rx_pkt_count", c, 32'(rx_pkt_count[c*16 +: 16]), 32'(exp_rxc[c]));
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; usr_wr = '0; usr_wdata = '0; usr_rd = '0;
      noc_credit_i = '0; noc_tx = '1; noc_data_out = '0;

      // Reset with the router offering flits on every channel.
      tick();
      chk_en = 1'b1;
      check("lit_rst_credit", 0, 32'(noc_credit_o), 32'h0);
      check("lit_rst_rx", 0, 32'(noc_rx), 32'h0);
      tick();
      check("lit_rst_empty", 0, 32'(usr_empty), 32'hF);
      reset = 1'b0; noc_tx = '0;
      tick();
      check("lit_post_credit", 0, 32'(noc_credit_o), 32'hF);
      check("lit_post_empty", 0, 32'(usr_empty), 32'hF);
      check("lit_post_pulses", 0, 32'({pkt_sent, pkt_rcvd}), 32'h0);

      // Channel 0 TX packet concurrent with channel 3 zero-size RX packet.
      noc_credit_i[0] = 1'b1; usr_wr[0] = 1'b1; usr_wdata[0 +: 16] = 16'h0011;
      noc_tx[3] = 1'b1; noc_data_out[48 +: 16] = 16'h0033;
      tick();
      check("lit_s2_d0", 0, 32'(lane(noc_data_in, 0)), 32'h0011);
      check("lit_s5_hdr", 3, 32'(lane(usr_rdata, 3)), 32'h0033);
      check("lit_s5_hdr_eop", 3, 32'(usr_eop[3]), 32'h0);
      usr_wdata[0 +: 16] = 16'h0002; noc_data_out[48 +: 16] = 16'h0000;
      tick();
      check("lit_s2_d1", 0, 32'(lane(noc_data_in, 0)), 32'h0002);
      check("lit_s5_rcvd", 3, 32'(pkt_rcvd[3]), 32'h1);
      noc_tx[3] = 1'b0; usr_wdata[0 +: 16] = 16'hAAAA; usr_rd[3] = 1'b1;
      tick();
      check("lit_s2_d2", 0, 32'(lane(noc_data_in, 0)), 32'hAAAA);
      check("lit_s5_size", 3, 32'(lane(usr_rdata, 3)), 32'h0000);
      check("lit_s5_size_eop", 3, 32'(usr_eop[3]), 32'h1);
      check("lit_s5_rcvd_once", 3, 32'(pkt_rcvd[3]), 32'h0);
      usr_wdata[0 +: 16] = 16'hBBBB;
      tick();
      check("lit_s2_d3", 0, 32'(lane(noc_data_in, 0)), 32'hBBBB);
      check("lit_s2_no_early_sent", 0, 32'(pkt_sent[0]), 32'h0);
      check("lit_s5_drained", 3, 32'(usr_empty[3]), 32'h1);
      usr_wr[0] = 1'b0; usr_rd[3] = 1'b0;
      tick();
      check("lit_s2_sent", 0, 32'(pkt_sent), 32'h1);
      check("lit_s2_idle", 0, 32'(noc_rx[0]), 32'h0);
      tick();
      check("lit_s2_sent_once", 0, 32'(pkt_sent[0]), 32'h0);
`ifdef NOC_NI_STATS_EN
      check("lit_s2_txcnt", 0, 32'(tx_pkt_count[0 +: 16]), 32'h1);
      check("lit_s5_rxcnt", 3, 32'(rx_pkt_count[48 +: 16]), 32'h1);
`endif

      // Channel 1: credit stall on 0xAAAA, fill to full, write-while-full dropped.
      noc_credit_i[1] = 1'b1; usr_wr[1] = 1'b1; usr_wdata[16 +: 16] = 16'h0011;
      tick();
      usr_wdata[16 +: 16] = 16'h0002;
      tick();
      usr_wdata[16 +: 16] = 16'hAAAA;
      tick();
      check("lit_s3_head", 1, 32'(lane(noc_data_in, 1)), 32'hAAAA);
      noc_credit_i[1] = 1'b0; usr_wdata[16 +: 16] = 16'hBBBB;
      tick();
      check("lit_s3_hold1", 1, 32'({noc_rx[1], lane(noc_data_in, 1)}), 32'h1AAAA);
      usr_wdata[16 +: 16] = 16'h0012;
      tick();
      check("lit_s3_hold2", 1, 32'({noc_rx[1], lane(noc_data_in, 1)}), 32'h1AAAA);
      usr_wdata[16 +: 16] = 16'h0000;
      tick();
      check("lit_s3_hold3", 1, 32'({noc_rx[1], lane(noc_data_in, 1)}), 32'h1AAAA);
      check("lit_s3_full", 1, 32'(usr_full[1]), 32'h1);
      noc_credit_i[1] = 1'b1; usr_wdata[16 +: 16] = 16'h7777;
      tick();
      check("lit_s3_resume", 1, 32'(lane(noc_data_in, 1)), 32'hBBBB);
      check("lit_s3_notfull", 1, 32'(usr_full[1]), 32'h0);
      usr_wr[1] = 1'b0;
      tick();
      check("lit_s3_sent1", 1, 32'(pkt_sent[1]), 32'h1);
      tick();
      check("lit_s3_zero_size", 1, 32'(lane(noc_data_in, 1)), 32'h0000);
      tick();
      check("lit_s3_sent2", 1, 32'(pkt_sent[1]), 32'h1);
      check("lit_s3_dropped", 1, 32'(noc_rx[1]), 32'h0);
      tick();
`ifdef NOC_NI_STATS_EN
      check("lit_s3_txcnt", 1, 32'(tx_pkt_count[16 +: 16]), 32'h2);
`endif

      // Channel 2 RX: fill to DEPTH, fifth flit held until one pop frees space.
      noc_tx[2] = 1'b1; noc_data_out[32 +: 16] = 16'h0022;
      tick();
      noc_data_out[32 +: 16] = 16'h0003;
      tick();
      noc_data_out[32 +: 16] = 16'h0001;
      tick();
      noc_data_out[32 +: 16] = 16'h0002;
      tick();
      check("lit_s4_credit_off", 2, 32'(noc_credit_o[2]), 32'h0);
      noc_data_out[32 +: 16] = 16'h0003;
      tick();
      check("lit_s4_held", 2, 32'(usr_full == 4'h0 && usr_empty[2] == 1'b0), 32'h1);
      check("lit_s4_head", 2, 32'(lane(usr_rdata, 2)), 32'h0022);
      usr_rd[2] = 1'b1;
      tick();
      check("lit_s4_credit_back", 2, 32'(noc_credit_o[2]), 32'h1);
      check("lit_s4_no_rcvd", 2, 32'(pkt_rcvd[2]), 32'h0);
      usr_rd[2] = 1'b0;
      tick();
      check("lit_s4_rcvd", 2, 32'(pkt_rcvd[2]), 32'h1);
      noc_tx[2] = 1'b0; usr_rd[2] = 1'b1;
      tick();
      tick();
      tick();
      check("lit_s4_last", 2, 32'({usr_eop[2], lane(usr_rdata, 2)}), 32'h10003);
      tick();
      check("lit_s4_empty", 2, 32'(usr_empty[2]), 32'h1);
      usr_rd[2] = 1'b0;
`ifdef NOC_NI_STATS_EN
      check("lit_s4_rxcnt", 2, 32'(rx_pkt_count[32 +: 16]), 32'h1);
`endif

      // Reset in the middle of a buffered TX packet and a partial RX packet.
      noc_credit_i[0] = 1'b0; usr_wr[0] = 1'b1; usr_wdata[0 +: 16] = 16'h0044;
      noc_tx[2] = 1'b1; noc_data_out[32 +: 16] = 16'h0055;
      tick();
      usr_wdata[0 +: 16] = 16'h0005; noc_data_out[32 +: 16] = 16'h0002;
      tick();
      usr_wr[0] = 1'b0; noc_tx[2] = 1'b0; reset = 1'b1;
      tick();
      check("lit_s6_rst_rx", 0, 32'(noc_rx), 32'h0);
      check("lit_s6_rst_empty", 0, 32'(usr_empty), 32'hF);
      reset = 1'b0;
      tick();
      check("lit_s6_no_pulse", 0, 32'({pkt_sent, pkt_rcvd}), 32'h0);
`ifdef NOC_NI_STATS_EN
      check("lit_s6_cnt_clr", 0, 32'(tx_pkt_count[0 +: 16]), 32'h0);
`endif
      // Parser must restart at the header after reset.
      noc_credit_i[0] = 1'b1; usr_wr[0] = 1'b1; usr_wdata[0 +: 16] = 16'h0066;
      tick();
      usr_wdata[0 +: 16] = 16'h0000;
      tick();
      usr_wr[0] = 1'b0;
      tick();
      check("lit_s6_restart_sent", 0, 32'(pkt_sent[0]), 32'h1);
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
